// File: rtl/dispatch_unit.sv
// In-order Tomasulo dispatch: pops the IB head, renames through a 16-entry register
// status file, issues to the ALU/LD reservation stations and resolves jumps locally.
module dispatch_unit #(
    parameter int TAGW = 4,
    parameter int NREG = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ib_empty,
    input  logic [15:0]        ib_data_out,
    output logic               ib_pop,
    output logic               ib_flush,
    output logic               branch_taken,
    output logic [15:0]        branch_target,
    input  logic               alu_free,
    input  logic [TAGW-1:0]    alu_free_tag,
    input  logic               ld_free,
    input  logic [TAGW-1:0]    ld_free_tag,
    output logic               issue_valid,
    output logic               issue_unit,
    output logic [TAGW-1:0]    issue_tag,
    output logic               src0_rdy,
    output logic               src1_rdy,
    output logic [15:0]        src0_val,
    output logic [15:0]        src1_val,
    output logic [TAGW-1:0]    src0_tag,
    output logic [TAGW-1:0]    src1_tag,
    input  logic               cdb_valid,
    input  logic [TAGW-1:0]    cdb_tag,
    input  logic [15:0]        cdb_val,
    output logic               halted,
    input  logic [3:0]         dbg_raddr,
    output logic [TAGW+16:0]   dbg_rdata,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAITZ = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_JZ   = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t            state;
    logic              reg_busy [NREG];
    logic [TAGW-1:0]   reg_tag  [NREG];
    logic [15:0]       reg_val  [NREG];
    logic [TAGW-1:0]   wait_tag;
    logic [15:0]       wait_target;

    logic [3:0] op, ra, rb, rt;
    logic       is_add, is_ld, can_go;

    assign op = ib_data_out[15:12];
    assign ra = ib_data_out[11:8];
    assign rb = ib_data_out[7:4];
    assign rt = ib_data_out[3:0];

    assign is_add = (op == OP_ADD);
    assign is_ld  = (op == OP_LD);

    // Handshakes: ib_pop is a ready to the show-ahead IB (head valid = !ib_empty) and
    // issue_valid is a valid to the RS whose free flag is its ready; each transfer
    // completes at the posedge where both sides are high, and nothing is held across cycles.
    always_comb begin
        can_go = 1'b1;
        if (is_add) can_go = alu_free;
        if (is_ld)  can_go = ld_free;
    end

    assign ib_pop      = rst_n && (state == S_RUN) && !ib_empty && can_go;
    assign issue_valid = ib_pop && (is_add || is_ld);
    assign issue_unit  = is_ld;
    assign issue_tag   = is_ld ? ld_free_tag : alu_free_tag;

    // Operand read with same-cycle CDB bypass; always reflects pre-rename state.
    always_comb begin
        src0_rdy = 1'b1;
        src0_val = reg_val[ra];
        src0_tag = reg_tag[ra];
        if (reg_busy[ra]) begin
            if (cdb_valid && (cdb_tag == reg_tag[ra])) src0_val = cdb_val;
            else                                       src0_rdy = 1'b0;
        end
        src1_rdy = 1'b1;
        src1_val = reg_val[rb];
        src1_tag = reg_tag[rb];
        if (reg_busy[rb]) begin
            if (cdb_valid && (cdb_tag == reg_tag[rb])) src1_val = cdb_val;
            else                                       src1_rdy = 1'b0;
        end
    end

    assign dbg_rdata = {reg_busy[dbg_raddr], reg_tag[dbg_raddr], reg_val[dbg_raddr]};
    assign dbg_state = state;

    // Register status file: CDB retirement first, so a same-cycle rename overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                reg_busy[i] <= 1'b0;
                reg_tag[i]  <= '0;
                reg_val[i]  <= '0;
            end
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < NREG; i++) begin
                    if (reg_busy[i] && (reg_tag[i] == cdb_tag)) begin
                        reg_busy[i] <= 1'b0;
                        reg_val[i]  <= cdb_val;
                    end
                end
            end
            if (issue_valid) begin
                reg_busy[rt] <= 1'b1;
                reg_tag[rt]  <= issue_tag;
            end else if (ib_pop && (op == OP_MOV)) begin
                reg_busy[rt] <= 1'b0;
                reg_val[rt]  <= {8'b0, ib_data_out[11:4]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RUN;
            ib_flush      <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            halted        <= 1'b0;
            wait_tag      <= '0;
            wait_target   <= '0;
        end else begin
            ib_flush     <= 1'b0;
            branch_taken <= 1'b0;
            case (state)
                S_RUN: begin
                    if (ib_pop) begin
                        case (op)
                            OP_JMP: begin
                                branch_taken  <= 1'b1;
                                ib_flush      <= 1'b1;
                                branch_target <= {4'b0, ib_data_out[11:0]};
                                state         <= S_FLUSH;
                            end
                            OP_JZ: begin
                                if (src0_rdy) begin
                                    if (src0_val == 16'd0) begin
                                        branch_taken  <= 1'b1;
                                        ib_flush      <= 1'b1;
                                        branch_target <= {8'b0, ib_data_out[7:0]};
                                        state         <= S_FLUSH;
                                    end
                                end else begin
                                    wait_tag    <= src0_tag;
                                    wait_target <= {8'b0, ib_data_out[7:0]};
                                    state       <= S_WAITZ;
                                end
                            end
                            OP_HALT: begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAITZ: begin
                    if (cdb_valid && (cdb_tag == wait_tag)) begin
                        if (cdb_val == 16'd0) begin
                            branch_taken  <= 1'b1;
                            ib_flush      <= 1'b1;
                            branch_target <= wait_target;
                            state         <= S_FLUSH;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_FLUSH: state <= S_RUN;
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
